// File: rtl/vga_pkg.sv
// Shared constants, enums and colour helper for the VGA colour-bar path (640x480@72).
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 40;
    localparam int H_BP     = 128;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 9;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 28;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FRAMES_PER_PATTERN = 72;
    localparam int SCROLL_STEP        = 4;

    localparam int COLOR_W = 3;
    localparam int CNT_W   = 10;
    localparam int FCNT_W  = 8;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_INV   = 2'd1,
        PAT_WHITE = 2'd2,
        PAT_BLACK = 2'd3
    } pattern_t;

    typedef enum logic {
        SCH_RUN     = 1'b0,
        SCH_ADVANCE = 1'b1
    } sched_state_t;

    function automatic logic [COLOR_W-1:0] pattern_color(input pattern_t pat,
                                                         input logic [COLOR_W-1:0] bar);
        case (pat)
            PAT_BARS:  pattern_color = bar;
            PAT_INV:   pattern_color = ~bar;
            PAT_WHITE: pattern_color = '1;
            default:   pattern_color = '0;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters with combinational sync, visible-area and frame strobes.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    output logic [vga_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_pkg::CNT_W-1:0] v_cnt,
    output logic                      hsync_n,
    output logic                      vsync_n,
    output logic                      active,
    output logic                      frame_start,
    output logic                      frame_wrap
);
    import vga_pkg::*;

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == CNT_W'(LINE_LEN - 1));
    assign v_last = (v_cnt == CNT_W'(FRAME_LINES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign hsync_n = !((h_cnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                       (h_cnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_n = !((v_cnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                       (v_cnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    assign active      = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign frame_wrap  = enable && h_last && v_last;

endmodule

// File: rtl/vga_bars_sequencer.sv
// VGA timing, pattern scheduler and registered colour/sync outputs for the colour-bar generator.
// Optional horizontal scroll of the visible area: define VGA_BARS_SCROLL_EN.
//
// state       | meaning
// SCH_RUN     | counting frame wraps for the current pattern
// SCH_ADVANCE | one clock at frame start: step pattern, clear frame counter
module vga_bars_sequencer #(
    parameter int H_ACTIVE           = vga_pkg::H_ACTIVE,
    parameter int H_FP               = vga_pkg::H_FP,
    parameter int H_SYNC             = vga_pkg::H_SYNC,
    parameter int H_BP               = vga_pkg::H_BP,
    parameter int V_ACTIVE           = vga_pkg::V_ACTIVE,
    parameter int V_FP               = vga_pkg::V_FP,
    parameter int V_SYNC             = vga_pkg::V_SYNC,
    parameter int V_BP               = vga_pkg::V_BP,
    parameter int FRAMES_PER_PATTERN = vga_pkg::FRAMES_PER_PATTERN
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [vga_pkg::COLOR_W-1:0] bar_color,
    output logic [vga_pkg::CNT_W-1:0]   x_px,
    output logic [vga_pkg::CNT_W-1:0]   y_px,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        active,
    output logic [vga_pkg::COLOR_W-1:0] color_px,
    output logic                        frame_tick,
    output logic [1:0]                  pattern
);
    import vga_pkg::*;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hsync_n_d;
    logic             vsync_n_d;
    logic             active_d;
    logic             frame_start;
    logic             frame_wrap;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hsync_n     (hsync_n_d),
        .vsync_n     (vsync_n_d),
        .active      (active_d),
        .frame_start (frame_start),
        .frame_wrap  (frame_wrap)
    );

    assign y_px = v_cnt;

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [FCNT_W-1:0] fcnt_q;
    pattern_t          pat_q;
    pattern_t          pat_sel;
    logic              advance;
    logic              fcnt_last;
    logic              fcnt_inc;

    assign fcnt_last = (fcnt_q == FCNT_W'(FRAMES_PER_PATTERN - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCH_RUN;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCH_RUN:     if (frame_wrap && fcnt_last) state_d = SCH_ADVANCE;
            SCH_ADVANCE: state_d = SCH_RUN;
            default:     state_d = SCH_RUN;
        endcase
    end

    // ADVANCE coincides with pixel (0,0): colour it with the incoming pattern so no frame is torn.
    always_comb begin
        advance  = (state_q == SCH_ADVANCE);
        fcnt_inc = (state_q == SCH_RUN) && frame_wrap && !fcnt_last;
        pat_sel  = advance ? pattern_t'(pat_q + 2'd1) : pat_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
            pat_q  <= PAT_BARS;
        end else if (enable) begin
            if (advance) begin
                fcnt_q <= '0;
                pat_q  <= pat_sel;
            end else if (fcnt_inc) begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end
    end

    assign pattern = pat_q;

`ifdef VGA_BARS_SCROLL_EN
    logic [CNT_W-1:0] offset_q;
    logic [CNT_W:0]   off_sum;
    logic [CNT_W:0]   x_sum;

    assign off_sum = {1'b0, offset_q} + (CNT_W+1)'(SCROLL_STEP);
    assign x_sum   = {1'b0, h_cnt} + {1'b0, offset_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offset_q <= '0;
        end else if (frame_wrap) begin
            offset_q <= (off_sum >= (CNT_W+1)'(H_ACTIVE)) ?
                        CNT_W'(off_sum - (CNT_W+1)'(H_ACTIVE)) : off_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        x_px = h_cnt;
        if (h_cnt < CNT_W'(H_ACTIVE)) begin
            x_px = (x_sum >= (CNT_W+1)'(H_ACTIVE)) ?
                   CNT_W'(x_sum - (CNT_W+1)'(H_ACTIVE)) : x_sum[CNT_W-1:0];
        end
    end
`else
    assign x_px = h_cnt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            active     <= 1'b0;
            color_px   <= '0;
            frame_tick <= 1'b0;
        end else if (enable) begin
            hsync      <= hsync_n_d;
            vsync      <= vsync_n_d;
            active     <= active_d;
            color_px   <= active_d ? pattern_color(pat_sel, bar_color) : '0;
            frame_tick <= frame_start;
        end else begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            active     <= 1'b0;
            color_px   <= '0;
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_bars_sequencer.sv
// Bench for vga_bars_sequencer on a shrunken raster (25x10 clocks/frame) with a frame-level model.
module tb_vga_bars_sequencer;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
    localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FPP = 2;
    localparam int NREC = 2260;
`ifdef VGA_BARS_SCROLL_EN
    localparam int SCROLL = vga_pkg::SCROLL_STEP;
`else
    localparam int SCROLL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [2:0] bar_color;
    logic [9:0] x_px, y_px;
    logic       hsync, vsync, active;
    logic [2:0] color_px;
    logic       frame_tick;
    logic [1:0] pattern;

    int n_checks = 0;
    int n_pass = 0;

    int mh = 0, mv = 0, mk = 0;
    logic       e_hs = 1'b1, e_vs = 1'b1, e_act = 1'b0, e_ft = 1'b0;
    logic [2:0] e_col = 3'b000;

    logic       r_hs [1:NREC];
    logic       r_vs [1:NREC];
    logic       r_act[1:NREC];
    logic       r_ft [1:NREC];
    logic [2:0] r_col[1:NREC];
    logic [1:0] r_pat[1:NREC];
    logic [9:0] r_x  [1:NREC];

    always #5 clk = ~clk;

    vga_bars_sequencer #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .FRAMES_PER_PATTERN (FPP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .bar_color  (bar_color),
        .x_px       (x_px),
        .y_px       (y_px),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .color_px   (color_px),
        .frame_tick (frame_tick),
        .pattern    (pattern)
    );

    // Eight equal bars; first is white, last is blue.
    function automatic logic [2:0] bars(input int x);
        int b;
        b = x / (HA / 8);
        if (b >= 7) return 3'b001;
        return 3'(7 - b);
    endfunction

    function automatic int pat_of(input int k);
        return (k / FPP) % 4;
    endfunction

    function automatic int xmap(input int h, input int k);
        return (h < HA) ? (h + (k * SCROLL) % HA) % HA : h;
    endfunction

    function automatic logic [2:0] apply(input int p, input logic [2:0] c);
        case (p)
            0:       return c;
            1:       return ~c;
            2:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign bar_color = bars(int'(x_px));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: raster position plus completed-frame count; pattern and scroll follow from the count.
    always @(posedge clk) begin
        if (!reset_n) begin
            mh = 0; mv = 0; mk = 0;
            e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_col = 3'b000; e_ft = 1'b0;
        end else if (enable) begin
            e_hs  = !(mh >= HA + HFP && mh < HA + HFP + HS);
            e_vs  = !(mv >= VA + VFP && mv < VA + VFP + VS);
            e_act = (mh < HA) && (mv < VA);
            e_col = e_act ? apply(pat_of(mk), bars(xmap(mh, mk))) : 3'b000;
            e_ft  = (mh == 0) && (mv == 0);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) begin
                    mv = 0;
                    mk++;
                end
            end
        end else begin
            e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_col = 3'b000; e_ft = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("x_px", int'(x_px), xmap(mh, mk));
            chk("y_px", int'(y_px), mv);
            chk("hsync", int'(hsync), int'(e_hs));
            chk("vsync", int'(vsync), int'(e_vs));
            chk("active", int'(active), int'(e_act));
            chk("color_px", int'(color_px), int'(e_col));
            chk("frame_tick", int'(frame_tick), int'(e_ft));
            if (!(mh == 0 && mv == 0)) chk("pattern", int'(pattern), pat_of(mk));
        end
    end

    initial begin
        int first, second, cnt, w;
        int pat_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_color", int'(color_px), 0);
        chk("rst_pattern", int'(pattern), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_tick", int'(frame_tick), 0);
        reset_n = 1'b1;

        for (int t = 1; t <= NREC; t++) begin
            @(posedge clk);
            #1;
            r_hs[t] = hsync; r_vs[t] = vsync; r_act[t] = active; r_ft[t] = frame_tick;
            r_col[t] = color_px; r_pat[t] = pattern; r_x[t] = x_px;
        end

        chk("first_tick", int'(r_ft[1]), 1);
        chk("col_x0", int'(r_col[1]), 7);
        chk("col_x1", int'(r_col[2]), 7);
        chk("col_x14", int'(r_col[15]), 1);

        second = 0;
        for (int t = 2; t <= NREC; t++) if (r_ft[t] && second == 0) second = t;
        chk("frame_period", second - 1, 250);

        first = 0; cnt = 0;
        for (int t = 1; t <= HT; t++) begin
            if (!r_hs[t]) cnt++;
            if (!r_hs[t] && first == 0) first = t;
        end
        chk("hsync_width", cnt, 3);
        chk("hsync_start", first, 19);
        second = 0;
        for (int t = HT + 1; t <= 2 * HT; t++) if (!r_hs[t] && second == 0) second = t;
        chk("line_period", second - first, 25);

        cnt = 0;
        for (int t = 1; t <= HT; t++) if (r_act[t]) cnt++;
        chk("active_per_line", cnt, 16);

        first = 0; cnt = 0;
        for (int t = 1; t <= 250; t++) begin
            if (!r_vs[t]) cnt++;
            if (!r_vs[t] && first == 0) first = t;
        end
        chk("vsync_width", cnt, 50);
        chk("vsync_start", first, 176);

        cnt = 0;
        for (int t = 1; t <= NREC; t++) if (!r_act[t] && r_col[t] != 3'b000) cnt++;
        chk("blank_colour", cnt, 0);

        for (int k = 0; k < 9; k++) chk("pattern_seq", int'(r_pat[250 * k + 50]), pat_seq[k]);
        chk("inv_x0", int'(r_col[501]), 0);
        chk("inv_x0_f3", int'(r_col[751]), 0);

        cnt = 0; first = 0;
        for (int t = 1001; t <= 1250; t++) begin
            if (r_act[t]) first++;
            if (r_act[t] && r_col[t] != 3'b111) cnt++;
        end
        chk("white_nonwhite", cnt, 0);
        chk("white_visible", first, 96);

        chk("scroll_f1", int'(r_x[250]), SCROLL % HA);
        chk("scroll_f2", int'(r_x[500]), (2 * SCROLL) % HA);
        chk("scroll_wrap", int'(r_x[1000]), 0);

        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (active) cnt++;
        end
        chk("gate_active", cnt, 0);
        chk("gate_x_hold", int'(x_px), (10 + (9 * SCROLL) % HA) % HA);
        chk("gate_y_hold", int'(y_px), 0);
        enable = 1'b1;

        w = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick) begin
                w = i;
                break;
            end
        end
        if (w == 0) w = 1000;
        chk("stretched_frame", (NREC + 7 + w) - 2251, 257);

        repeat (100) @(posedge clk);
        #1;
        chk("pre_rst_pattern", int'(pattern), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_x", int'(x_px), 0);
        chk("arst_y", int'(y_px), 0);
        chk("arst_hsync", int'(hsync), 1);
        chk("arst_vsync", int'(vsync), 1);
        chk("arst_color", int'(color_px), 0);
        chk("arst_pattern", int'(pattern), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
